mem_bus_arbiter: RTL and testbench
==================================

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 256, the cycles a granted transfer may wait for m_mem_ready before abort (used only when MEM_ARB_TIMEOUT_EN is defined).
REQ-002 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-003 SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports s_mem_valid0 / s_mem_valid1  input  1  transfer request from requester 0 (CPU) / requester 1 (DMA).
REQ-005 SHALL have ports s_mem_ready0 / s_mem_ready1  output  1  transfer-complete strobe per requester.
REQ-006 SHALL have ports s_mem_addr0/1, s_mem_wdata0/1  input  32  address and write data per requester.
REQ-007 SHALL have ports s_mem_wstrb0/1  input  4  byte write strobes per requester; 0 means read.
REQ-008 SHALL have ports s_mem_rdata0/1  output  32  read data per requester.
REQ-009 SHALL have ports m_mem_valid  output  1; m_mem_ready  input  1; m_mem_addr, m_mem_wdata  output  32; m_mem_wstrb  output  4; m_mem_rdata  input  32; the single shared downstream port feeding the interconnect.
REQ-010 SHALL have port arb_err  output  1  sticky timeout flag (tied 0 when MEM_ARB_TIMEOUT_EN is undefined).

Function
REQ-011 SHALL implement states IDLE, GRANT0, GRANT1 (plus ABORT when MEM_ARB_TIMEOUT_EN is defined).
REQ-012 SHALL, in IDLE, drive m_mem_valid=0, m_mem_addr/wdata/wstrb=0, both s_mem_ready=0, both s_mem_rdata=0.
REQ-013 SHALL, in IDLE with exactly one s_mem_validN=1, move to GRANTN next cycle (1-cycle arbitration latency).
REQ-014 SHALL, in IDLE with both valids=1, grant the requester not granted last (round-robin); last_grant resets to 1, so requester 0 wins the first tie.
REQ-015 SHALL, in GRANTN, pass s_mem_validN, addrN, wdataN, wstrbN combinationally to the m_mem_* outputs; the other requester sees ready=0, rdata=0.
REQ-016 SHALL, in GRANTN with m_mem_ready=1, assert s_mem_readyN=1 and s_mem_rdataN=m_mem_rdata in the same cycle, set last_grant=N, and return to IDLE next cycle.
REQ-017 SHALL hold GRANTN while m_mem_ready=0; requester 1 cannot preempt requester 0, and vice versa.
REQ-018 SHALL, in GRANTN with s_mem_validN=0 (requester withdrew), drive m_mem_valid=0 and return to IDLE next cycle without updating last_grant.
REQ-019 SHALL complete at most one transfer per grant; back-to-back transfers from one requester each pay the IDLE cycle (2-cycle minimum per transfer with zero-wait target).
REQ-020 SHALL ignore m_mem_ready when in IDLE.

Reset
REQ-021 SHALL, on resetn=0, asynchronously force state=IDLE, last_grant=1, timeout counter=0, arb_err=0, so that all outputs take their IDLE values.
REQ-022 SHALL, on reset mid-transfer, drop m_mem_valid immediately with no ready issued to either requester; the first post-reset arbitration follows REQ-013/014.

Configuration
REQ-023 SHALL, with macro MEM_ARB_TIMEOUT_EN defined, count cycles in GRANTN with m_mem_ready=0; on the count reaching TIMEOUT_CYCLES-1, enter ABORT.
REQ-024 SHALL, in ABORT, drive m_mem_valid=0, s_mem_readyN=1, s_mem_rdataN=32'hDEADBEEF for one cycle, set arb_err=1 (sticky until reset), update last_grant=N, then go to IDLE.
REQ-025 SHALL clear the timeout counter on every entry to GRANTN.
REQ-026 SHALL, without MEM_ARB_TIMEOUT_EN, omit the counter and ABORT state, tie arb_err=0, and wait indefinitely for m_mem_ready.

Verification
REQ-027 SHALL cover: valid0=1, addr0=0x20000004, wstrb0=0xF, wdata0=0x12345678, target ready after 1 cycle -> m_mem_* mirror requester 0 from cycle 1, ready0 pulses once, ready1 stays 0.
REQ-028 SHALL cover: valid0=valid1=1 held for 4 transfers, zero-wait target -> grants alternate 0,1,0,1, each transfer 2 cycles.
REQ-029 SHALL cover: requester 0 read of 0x10000000 stalled 5 cycles, valid1 raised in stall cycle 2 -> grant stays 0, rdata0=m_mem_rdata on ready cycle, requester 1 granted next.
REQ-030 SHALL cover: resetn pulsed low during GRANT1 -> m_mem_valid=0 asynchronously, no ready pulses, next tie goes to requester 0.
REQ-031 SHALL cover (MEM_ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES=16): target never ready -> ABORT after 16 grant cycles, ready0=1 with rdata0=0xDEADBEEF, arb_err=1 until reset.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Two-requester round-robin arbiter onto one memory port; 1-cycle arbitration, combinational pass-through while granted.
// Backpressure: a grant holds until m_mem_ready; optional MEM_ARB_TIMEOUT_EN aborts stalled grants with 0xDEADBEEF.
module mem_bus_arbiter #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        s_mem_valid0,
    input  logic        s_mem_valid1,
    output logic        s_mem_ready0,
    output logic        s_mem_ready1,
    input  logic [31:0] s_mem_addr0,
    input  logic [31:0] s_mem_addr1,
    input  logic [31:0] s_mem_wdata0,
    input  logic [31:0] s_mem_wdata1,
    input  logic [3:0]  s_mem_wstrb0,
    input  logic [3:0]  s_mem_wstrb1,
    output logic [31:0] s_mem_rdata0,
    output logic [31:0] s_mem_rdata1,
    output logic        m_mem_valid,
    input  logic        m_mem_ready,
    output logic [31:0] m_mem_addr,
    output logic [31:0] m_mem_wdata,
    output logic [3:0]  m_mem_wstrb,
    input  logic [31:0] m_mem_rdata,
    output logic        arb_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
`ifdef MEM_ARB_TIMEOUT_EN
        ,
        ABORT  = 2'd3
`endif
    } state_t;

    state_t state_q, state_d;
    logic   last_grant_q, last_grant_d;
    logic   sel;
    logic   sel_valid;

    assign sel       = (state_q == GRANT1);
    assign sel_valid = sel ? s_mem_valid1 : s_mem_valid0;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] to_cnt_q, to_cnt_d;
    logic          arb_err_q, arb_err_d;

    assign arb_err = arb_err_q;
`else
    assign arb_err = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        m_mem_valid  = 1'b0;
        m_mem_addr   = '0;
        m_mem_wdata  = '0;
        m_mem_wstrb  = '0;
        s_mem_ready0 = 1'b0;
        s_mem_ready1 = 1'b0;
        s_mem_rdata0 = '0;
        s_mem_rdata1 = '0;
`ifdef MEM_ARB_TIMEOUT_EN
        to_cnt_d     = to_cnt_q;
        arb_err_d    = arb_err_q;
`endif
        case (state_q)
            IDLE: begin
`ifdef MEM_ARB_TIMEOUT_EN
                to_cnt_d = '0;
`endif
                // On a tie the requester that did not finish last wins.
                if (s_mem_valid0 && s_mem_valid1) begin
                    state_d = last_grant_q ? GRANT0 : GRANT1;
                end else if (s_mem_valid0) begin
                    state_d = GRANT0;
                end else if (s_mem_valid1) begin
                    state_d = GRANT1;
                end
            end
            GRANT0, GRANT1: begin
                m_mem_valid = sel_valid;
                m_mem_addr  = sel ? s_mem_addr1  : s_mem_addr0;
                m_mem_wdata = sel ? s_mem_wdata1 : s_mem_wdata0;
                m_mem_wstrb = sel ? s_mem_wstrb1 : s_mem_wstrb0;
                if (!sel_valid) begin
                    // Withdrawn request: no completion, fairness history untouched.
                    state_d = IDLE;
                end else if (m_mem_ready) begin
                    if (sel) begin
                        s_mem_ready1 = 1'b1;
                        s_mem_rdata1 = m_mem_rdata;
                    end else begin
                        s_mem_ready0 = 1'b1;
                        s_mem_rdata0 = m_mem_rdata;
                    end
                    last_grant_d = sel;
                    state_d      = IDLE;
                end
`ifdef MEM_ARB_TIMEOUT_EN
                else if (to_cnt_q == TO_LAST) begin
                    last_grant_d = sel;
                    arb_err_d    = 1'b1;
                    state_d      = ABORT;
                end else begin
                    to_cnt_d = to_cnt_q + CW'(1);
                end
`endif
            end
`ifdef MEM_ARB_TIMEOUT_EN
            ABORT: begin
                // last_grant_q already names the requester whose grant expired.
                if (last_grant_q) begin
                    s_mem_ready1 = 1'b1;
                    s_mem_rdata1 = 32'hDEAD_BEEF;
                end else begin
                    s_mem_ready0 = 1'b1;
                    s_mem_rdata0 = 32'hDEAD_BEEF;
                end
                state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            to_cnt_q  <= '0;
            arb_err_q <= 1'b0;
        end else begin
            to_cnt_q  <= to_cnt_d;
            arb_err_q <= arb_err_d;
        end
    end
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: transaction-level owner model compared every cycle plus directed literal checks.
module tb_mem_bus_arbiter;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        resetn;
    logic        v[2];
    logic [31:0] a[2];
    logic [31:0] wd[2];
    logic [3:0]  ws[2];
    logic        sr[2];
    logic [31:0] srd[2];
    logic        m_valid, m_ready, arb_err;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [3:0]  m_wstrb;

    int checks = 0;
    int errors = 0;
    // Model: who owns the bus (-1 none, 0/1 requester, 2 abort), round-robin history, stall age.
    int owner, last, waited, abort_who;
    logic merr;
    int cyc = 0;
    int rc[2];
    int glog[$];
    int gstamp[$];
    int r0, r1;
    int exp_ord[4] = '{0, 1, 0, 1};
`ifdef MEM_ARB_TIMEOUT_EN
    int gcnt;
    int found;
`endif

    always #5 clk = ~clk;

    mem_bus_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .resetn(resetn),
        .s_mem_valid0(v[0]), .s_mem_valid1(v[1]),
        .s_mem_ready0(sr[0]), .s_mem_ready1(sr[1]),
        .s_mem_addr0(a[0]), .s_mem_addr1(a[1]),
        .s_mem_wdata0(wd[0]), .s_mem_wdata1(wd[1]),
        .s_mem_wstrb0(ws[0]), .s_mem_wstrb1(ws[1]),
        .s_mem_rdata0(srd[0]), .s_mem_rdata1(srd[1]),
        .m_mem_valid(m_valid), .m_mem_ready(m_ready),
        .m_mem_addr(m_addr), .m_mem_wdata(m_wdata), .m_mem_wstrb(m_wstrb),
        .m_mem_rdata(m_rdata), .arb_err(arb_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        owner = -1; last = 1; waited = 0; abort_who = 0; merr = 1'b0;
    endtask

    // Advance the model by the rules of one clock edge, using the inputs present before the edge.
    task automatic model_update();
        if (!resetn) begin
            model_reset();
        end else if (owner == -1) begin
            if (v[0] && v[1]) owner = (last == 1) ? 0 : 1;
            else if (v[0])    owner = 0;
            else if (v[1])    owner = 1;
            waited = 0;
        end else if (owner == 0 || owner == 1) begin
            if (!v[owner]) owner = -1;
            else if (m_ready) begin
                last = owner; owner = -1;
            end
`ifdef MEM_ARB_TIMEOUT_EN
            else if (waited == TO - 1) begin
                abort_who = owner; last = owner; merr = 1'b1; owner = 2;
            end else waited++;
`endif
        end else begin
            owner = -1;
        end
    endtask

    task automatic compare();
        logic        ev, er0, er1;
        logic [31:0] ea, ew, erd0, erd1;
        logic [3:0]  es;
        ev = 0; er0 = 0; er1 = 0; ea = 0; ew = 0; erd0 = 0; erd1 = 0; es = 0;
        if (owner == 0 || owner == 1) begin
            ev = v[owner]; ea = a[owner]; ew = wd[owner]; es = ws[owner];
            if (v[owner] && m_ready) begin
                if (owner == 0) begin er0 = 1; erd0 = m_rdata; end
                else begin er1 = 1; erd1 = m_rdata; end
            end
        end else if (owner == 2) begin
            if (abort_who == 0) begin er0 = 1; erd0 = 32'hDEADBEEF; end
            else begin er1 = 1; erd1 = 32'hDEADBEEF; end
        end
        chk("m_valid", m_valid, ev);
        chk("m_addr", m_addr, ea);
        chk("m_wdata", m_wdata, ew);
        chk("m_wstrb", m_wstrb, es);
        chk("ready0", sr[0], er0);
        chk("ready1", sr[1], er1);
        chk("rdata0", srd[0], erd0);
        chk("rdata1", srd[1], erd1);
        chk("arb_err", arb_err, merr);
        if (sr[0] === 1'b1) begin rc[0]++; glog.push_back(0); gstamp.push_back(cyc); end
        if (sr[1] === 1'b1) begin rc[1]++; glog.push_back(1); gstamp.push_back(cyc); end
    endtask

    task automatic mid();
        @(negedge clk);
        compare();
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        cyc++;
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) begin mid(); tick(); end
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        model_reset();
        run(2);
        resetn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        resetn = 1'b0;
        for (int i = 0; i < 2; i++) begin
            v[i] = 0; a[i] = 0; wd[i] = 0; ws[i] = 0; rc[i] = 0;
        end
        m_ready = 0; m_rdata = 0;
        model_reset();
        tick();
        mid();
        chk("rst_m_valid", m_valid, 1'b0);
        chk("rst_ready0", sr[0], 1'b0);
        chk("rst_arb_err", arb_err, 1'b0);
        tick();
        resetn = 1'b1;

        // Single CPU write, target ready on the second grant cycle.
        v[0] = 1; a[0] = 32'h20000004; ws[0] = 4'hF; wd[0] = 32'h12345678;
        mid(); chk("t1_idle_valid", m_valid, 1'b0); tick();
        mid();
        chk("t1_valid", m_valid, 1'b1);
        chk("t1_addr", m_addr, 32'h20000004);
        chk("t1_wdata", m_wdata, 32'h12345678);
        chk("t1_wstrb", m_wstrb, 4'hF);
        chk("t1_early_ready0", sr[0], 1'b0);
        tick();
        m_ready = 1;
        mid(); chk("t1_ready0", sr[0], 1'b1); chk("t1_ready1", sr[1], 1'b0); tick();
        v[0] = 0; m_ready = 0;
        mid(); chk("t1_ready0_drop", sr[0], 1'b0); tick();
        run(2);
        chk("t1_pulses0", rc[0], 1);
        chk("t1_pulses1", rc[1], 0);

        // Both requesting continuously against a zero-wait target.
        do_reset();
        glog.delete(); gstamp.delete();
        v[0] = 1; v[1] = 1; a[0] = 32'h00000100; a[1] = 32'h00000200;
        wd[0] = 32'hA0A0A0A0; wd[1] = 32'hB1B1B1B1; ws[0] = 4'hF; ws[1] = 4'h3;
        m_ready = 1; m_rdata = 32'h55AA55AA;
        run(8);
        v[0] = 0; v[1] = 0; m_ready = 0;
        run(2);
        chk("t2_transfers", glog.size(), 4);
        for (int i = 0; i < glog.size() && i < 4; i++) chk("t2_grant_order", glog[i], exp_ord[i]);
        for (int i = 1; i < gstamp.size() && i < 4; i++) chk("t2_spacing", gstamp[i] - gstamp[i-1], 2);

        // CPU read stalled five cycles; DMA raises its request mid-stall.
        v[0] = 1; a[0] = 32'h10000000; ws[0] = 0; wd[0] = 0; m_ready = 0;
        mid(); tick();
        for (int i = 1; i <= 5; i++) begin
            if (i == 2) begin v[1] = 1; a[1] = 32'h30000008; ws[1] = 0; wd[1] = 0; end
            mid();
            chk("t3_stall_addr", m_addr, 32'h10000000);
            chk("t3_stall_ready0", sr[0], 1'b0);
            chk("t3_stall_ready1", sr[1], 1'b0);
            tick();
        end
        m_ready = 1; m_rdata = 32'hCAFEF00D;
        mid();
        chk("t3_ready0", sr[0], 1'b1);
        chk("t3_rdata0", srd[0], 32'hCAFEF00D);
        chk("t3_ready1_held", sr[1], 1'b0);
        tick();
        v[0] = 0;
        mid(); chk("t3_idle_valid", m_valid, 1'b0); chk("t3_idle_ready1", sr[1], 1'b0); tick();
        mid();
        chk("t3_g1_addr", m_addr, 32'h30000008);
        chk("t3_ready1", sr[1], 1'b1);
        chk("t3_rdata1", srd[1], 32'hCAFEF00D);
        tick();
        v[1] = 0; m_ready = 0;
        run(1);

        // Asynchronous reset while DMA holds a stalled grant.
        v[1] = 1; a[1] = 32'h40000000;
        mid(); tick();
        mid();
        chk("t4_g1_valid", m_valid, 1'b1);
        chk("t4_g1_addr", m_addr, 32'h40000000);
        r0 = rc[0]; r1 = rc[1];
        #1 resetn = 1'b0;
        model_reset();
        #1;
        chk("t4_async_valid", m_valid, 1'b0);
        chk("t4_async_ready1", sr[1], 1'b0);
        v[0] = 1; a[0] = 32'h50000000;
        tick();
        mid(); tick();
        resetn = 1'b1;
        mid();
        chk("t4_pulses0", rc[0], r0);
        chk("t4_pulses1", rc[1], r1);
        tick();
        mid();
        chk("t4_tie_valid", m_valid, 1'b1);
        chk("t4_tie_addr", m_addr, 32'h50000000);
        tick();
        m_ready = 1;
        mid(); chk("t4_ready0", sr[0], 1'b1); tick();
        v[0] = 0; v[1] = 0; m_ready = 0;
        run(1);

        // DMA withdraws mid-grant; the next tie must still favour DMA.
        v[1] = 1; a[1] = 32'h60000000;
        mid(); tick();
        mid(); chk("t5_grant_valid", m_valid, 1'b1); tick();
        v[1] = 0; m_ready = 1;
        mid(); chk("t5_wd_valid", m_valid, 1'b0); chk("t5_wd_ready1", sr[1], 1'b0); tick();
        m_ready = 0; v[0] = 1; v[1] = 1;
        mid(); tick();
        mid(); chk("t5_tie_addr", m_addr, 32'h60000000); tick();
        m_ready = 1;
        mid(); chk("t5_ready1", sr[1], 1'b1); tick();
        v[0] = 0; v[1] = 0; m_ready = 0;
        run(1);

`ifdef MEM_ARB_TIMEOUT_EN
        // Target never answers: grant expires after TO cycles.
        v[0] = 1; a[0] = 32'h70000000; ws[0] = 0; m_ready = 0; m_rdata = 32'h11111111;
        gcnt = 0; found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            mid();
            if (sr[0] === 1'b1) begin
                found = 1;
                chk("t6_abort_rdata0", srd[0], 32'hDEADBEEF);
                chk("t6_abort_err", arb_err, 1'b1);
                chk("t6_abort_valid", m_valid, 1'b0);
            end else if (m_valid === 1'b1) begin
                gcnt++;
            end
            tick();
        end
        chk("t6_abort_seen", found, 1);
        chk("t6_grant_cycles", gcnt, 16);
        v[0] = 0;
        run(3);
        chk("t6_err_sticky", arb_err, 1'b1);
        do_reset();
        mid(); chk("t6_err_cleared", arb_err, 1'b0); tick();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
